fifo_stream_adapter: RTL and testbench

//  Downstream drain stage for the team FIFO. Turns the FIFO read side (rd strobe,

---
 rtl/fifo_stream_adapter.sv | 84 ++++++++
 tb/tb_fifo_stream_adapter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// FIFO read side to valid/ready stream adapter.
// A 2-entry skid buffer plus one tracked in-flight read keeps full throughput
// under backpressure; beats are framed into bursts of BURST_LEN with out_last.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN  = 8,
  localparam int IDX_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  input  logic                  fifo_mty,
  output logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [IDX_W-1:0]      beat_idx
);

  // Encoding doubles as the buffer occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  state_e                         state_q, state_d;
  logic                           inflight_q;
  logic                           head_q, head_d;
  logic [1:0][DATA_WIDTH-1:0]     entry_q, entry_d;
  logic [IDX_W-1:0]               beat_q, beat_d;

  logic       pop, capture, tail, at_last;
  logic [2:0] occ;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = entry_q[head_q];
  assign at_last   = (beat_q == IDX_W'(BURST_LEN - 1));
  assign out_last  = out_valid & at_last;
  assign beat_idx  = beat_q;

  assign pop     = out_valid & out_ready;
  assign capture = inflight_q;
  assign tail    = head_q ^ (state_q == ONE);
  assign occ     = {1'b0, state_q} + {2'b00, inflight_q};
  // A read may be issued into the slot freed by this cycle's pop.
  assign fifo_rd = !rst & en & !fifo_mty & (occ < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    entry_d = entry_q;
    beat_d  = beat_q;
    if (capture) entry_d[tail] = fifo_q;
    if (pop) begin
      head_d = ~head_q;
      beat_d = at_last ? '0 : beat_q + IDX_W'(1);
    end
    unique case (state_q)
      EMPTY:   if (capture) state_d = ONE;
      ONE: begin
        if (capture && !pop)      state_d = TWO;
        else if (pop && !capture) state_d = EMPTY;
      end
      TWO:     if (pop && !capture) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      entry_q    <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd;
      head_q     <= head_d;
      entry_q    <= entry_d;
      beat_q     <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: array-backed FIFO model, expected-beat queue
// scoreboard and outstanding-read accounting, driven by directed and random steps.
module tb_fifo_stream_adapter;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst, en, fifo_mty, fifo_rd, out_valid, out_ready, out_last;
  logic [DW-1:0] fifo_q, out_data;
  logic [1:0]    beat_idx;

  fifo_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_q(fifo_q), .fifo_mty(fifo_mty),
    .fifo_rd(fifo_rd), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .beat_idx(beat_idx)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, combinational empty flag.
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_clr;
  assign fifo_mty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_rd) begin
      fifo_q <= mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];
  int total = 0, bad = 0;
  int nbeats = 0, reads = 0, pops = 0, cyc = 0;
  int first_rd = -1, first_pop = -1, last_pop = -1;
  logic          hold_prev = 1'b0;
  logic          hold_last;
  logic [DW-1:0] hold_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr % 256] = v;
    wr_ptr++;
    exp_q.push_back(v);
  endtask

  // Called at a negedge with inputs set; checks this cycle, advances to next negedge.
  task automatic cycle();
    logic [DW-1:0] e;
    #1;
    if (!rst) begin
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
        chk("hold_last", out_last, hold_last);
      end
      if (out_valid && out_ready) begin
        chk("beat_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e);
          chk("beat_idx", beat_idx, nbeats % BL);
          chk("beat_last", out_last, (nbeats % BL) == BL - 1);
        end
        nbeats++;
        pops++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (fifo_rd) begin
        reads++;
        if (first_rd < 0) first_rd = cyc;
      end
      chk("outstanding_le2", (reads - pops) <= 2, 1);
      if (!en) chk("rd_while_disabled", fifo_rd, 0);
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (exp_q.size() != 0 || out_valid); i++) begin
      en = 1'b1;
      out_ready = 1'b1;
      cycle();
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    int r0;
    rst = 1'b1; en = 1'b1; out_ready = 1'b0; fifo_clr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_idx", beat_idx, 0);
    chk("rst_rd", fifo_rd, 0);
    @(negedge clk);
    rst = 1'b0; fifo_clr = 1'b0;

    // Empty FIFO: no reads, no output.
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      #1;
      chk("empty_rd", fifo_rd, 0);
      chk("empty_valid", out_valid, 0);
      cycle();
    end

    // Back-to-back burst with latency check.
    first_rd = -1; first_pop = -1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    drain();
    chk("latency", first_pop - first_rd, 2);
    chk("back_to_back", last_pop - first_pop, 7);

    // Stalled consumer: only two reads outstanding, head held.
    for (int i = 1; i <= 8; i++) push(DW'(i));
    r0 = reads;
    for (int i = 0; i < 20; i++) begin out_ready = 1'b0; cycle(); end
    chk("stall_rd_pulses", reads - r0, 2);
    chk("stall_head", out_data, 1);
    drain();

    // Toggling ready, random data.
    for (int i = 0; i < 16; i++) push(DW'($urandom));
    for (int i = 0; i < 40; i++) begin out_ready = i[0] ? 1'b0 : 1'b1; cycle(); end
    drain();

    // FIFO runs dry mid-burst, then resumes.
    push(DW'(1)); push(DW'(2));
    for (int i = 0; i < 10; i++) begin out_ready = 1'b1; cycle(); end
    #1;
    chk("dry_valid", out_valid, 0);
    chk("dry_idx", beat_idx, 2);
    push(DW'(3)); push(DW'(4));
    drain();

    // Random ready and enable.
    for (int i = 0; i < 20; i++) push(DW'($urandom));
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Reset with a buffered beat and a read in flight.
    for (int i = 0; i < 4; i++) push(DW'(32'h100 + i));
    out_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b1; fifo_clr = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_idx", beat_idx, 0);
    chk("rst2_rd", fifo_rd, 0);
    @(negedge clk);
    rst = 1'b0; fifo_clr = 1'b0;
    reads = 0; pops = 0; nbeats = 0; hold_prev = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b1;
      #1;
      chk("post_rst_valid", out_valid, 0);
      cycle();
    end
    push(DW'(32'hA5));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
